vrf_seq: RTL and testbench
==========================

Name: vrf_seq

Overview:
Command sequencer and write-port arbiter for the 32x64 vector register file (VRF). It accepts a vector command (source base, destination base, count) and, per element, reads an operand pair from the VRF, kicks the compute unit (CU), waits for its result and writes the result back. It also shares the single VRF write port between CU writeback and an external load port. It sits between the instruction front-end, the VRF and the CU.

Parameters:
ADDR_W, 5, VRF address width (32 entries; all pointer arithmetic is mod 2^ADDR_W).
DATA_W, 64, VRF word width.
TIMEOUT_CYCLES, 255, CU watchdog limit. Used only with VRF_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset (rst==0 resets)
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_src  in  ADDR_W  first operand-pair address
cmd_dst  in  ADDR_W  first result address
cmd_len  in  ADDR_W  number of elements (0 = no-op)
done  out  1  one-cycle pulse at command end
err  out  1  one-cycle pulse with done on CU timeout
vrf_r_am  out  2  VRF read mode (2'b01 = read pair)
vrf_r_addr  out  ADDR_W  VRF read address
vrf_w_am  out  2  VRF write mode (2'b01 = write)
vrf_w_addr  out  ADDR_W  VRF write address
vrf_w_data  out  DATA_W  VRF write data
cu_start  out  1  one-cycle CU kick; operands are the VRF data_out1/data_out2 of that cycle
cu_done  in  1  CU result valid
cu_result  in  DATA_W  CU result
ld_valid  in  1  external load write request
ld_ready  out  1  load accepted when ld_valid&&ld_ready
ld_addr  in  ADDR_W  load address
ld_data  in  DATA_W  load data

Behaviour:
- Reset (rst==0, asynchronous): state IDLE; cmd_ready=1; done, err, cu_start = 0; vrf_r_am and vrf_w_am = 2'b00; addresses and data = 0; internal pointers, count and result register = 0. An in-flight element is dropped and no write is issued.
- State machine: IDLE, READ, ISSUE, WAIT_CU, WRITE, DONE.
- IDLE: cmd_ready=1. On a handshake, latch src_ptr=cmd_src, dst_ptr=cmd_dst, cnt=cmd_len. Go to DONE if cmd_len==0, otherwise to READ.
- READ: vrf_r_am=01, vrf_r_addr=src_ptr. The VRF registers pair (src_ptr, src_ptr+1 mod 32).
- ISSUE: VRF outputs are valid; cu_start=1 for exactly one cycle.
- WAIT_CU: cu_done is sampled only in this state (ignored elsewhere). On cu_done, capture cu_result and go to WRITE.
- WRITE: vrf_w_am=01, vrf_w_addr=dst_ptr, vrf_w_data=result. Then src_ptr+=2, dst_ptr+=1 (both wrap mod 32) and cnt-=1. Go to DONE if cnt becomes 0, otherwise to READ.
- DONE: done=1 for one cycle, then IDLE.
- cmd_ready=0 in every state except IDLE.
- Minimum element latency is 4 cycles (READ, ISSUE, WAIT with cu_done in its first cycle, WRITE).
- All FSM-driven outputs decode from registered state only.
- Write port: WRITE has absolute priority, and ld_ready=0 in WRITE. In every other state ld_ready=1, and vrf_w_am/addr/data mux combinationally from the ld_* inputs when ld_valid. A load may target any address, including one a running command will read later. Ordering is by cycle; there is no hazard protection.
- Read port: only the FSM drives it; vrf_r_am=00 outside READ.
- Wrap: src_ptr=31 reads pair (31,0); src_ptr=30 advances to 0.

Optional Feature:
VRF_SEQ_TIMEOUT_EN:
- Defined: a counter clears on entering WAIT_CU and increments each cycle there. If it reaches TIMEOUT_CYCLES without cu_done, go to DONE with err=1 together with done. The element write and all remaining elements are abandoned.
- Undefined: WAIT_CU waits indefinitely and err is tied 0.

Decomposition:
- Shared package vrf_pkg: ADDR_W, DATA_W, AM_IDLE=2'b00, AM_RW=2'b01, and the FSM state enum.
- One natural sub-module, vrf_seq_wdog: the timeout counter, instantiated only under VRF_SEQ_TIMEOUT_EN.
- The rest stays flat.

Test Plan:
- Command src=4, dst=10, len=2; CU returns cu_done 1 cycle after cu_start with results 0xA1 and 0xB2. Required response:
  - reads at 4 then 6;
  - writes 0xA1 to address 10 and 0xB2 to address 11;
  - done exactly 9 cycles after the accept cycle.
- Command src=31, len=1 -> VRF presents pair (31,0). Command src=30, len=2 -> second read at address 0.
- Command len=0 -> done pulses the cycle after accept; no read or write strobes.
- ld_valid held during a command -> ld_ready=0 exactly in WRITE cycles. Loads land in all other cycles; CU writes are never lost.
- Reset asserted in WAIT_CU -> immediately back to IDLE, all outputs zero, no write to dst. A new command after reset runs normally.
- With VRF_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, CU never responds -> done=1 and err=1 eight cycles after entering WAIT_CU, with no write. Without the macro, the block remains in WAIT_CU.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared widths, access-mode encodings and sequencer state enum for the VRF command path.
package vrf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    localparam logic [1:0] AM_IDLE = 2'b00;
    localparam logic [1:0] AM_RW   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ISSUE,
        ST_WAIT_CU,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vrf_seq_wdog.sv
// CU watchdog: counts cycles spent waiting for the CU and flags expiry on the last allowed cycle.
// Counter holds zero whenever run_i is low, so it restarts on every entry into the wait state.
module vrf_seq_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose closing edge would make the count reach the limit.
    assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vrf_seq.sv
// VRF command sequencer and write-port arbiter; optional CU watchdog under VRF_SEQ_TIMEOUT_EN.
// Per element: READ, ISSUE, WAIT_CU, WRITE (4 cycles minimum); WRITE owns the write port, loads get it otherwise.
module vrf_seq
    import vrf_pkg::*;
#(
    parameter int ADDR_W         = vrf_pkg::ADDR_W,
    parameter int DATA_W         = vrf_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              done,
    output logic              err,
    output logic [1:0]        vrf_r_am,
    output logic [ADDR_W-1:0] vrf_r_addr,
    output logic [1:0]        vrf_w_am,
    output logic [ADDR_W-1:0] vrf_w_addr,
    output logic [DATA_W-1:0] vrf_w_data,
    output logic              cu_start,
    input  logic              cu_done,
    input  logic [DATA_W-1:0] cu_result,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              timeout;

`ifdef VRF_SEQ_TIMEOUT_EN
    logic err_q, err_d;

    vrf_seq_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .run_i    (state_q == ST_WAIT_CU),
        .expired_o(timeout)
    );

    always_comb begin
        err_d = err_q;
        if (state_q == ST_DONE) begin
            err_d = 1'b0;
        end else if (state_q == ST_WAIT_CU && !cu_done && timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = (state_q == ST_DONE) && err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    cnt_d   = cmd_len;
                    state_d = (cmd_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ:  state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT_CU;
            ST_WAIT_CU: begin
                if (cu_done) begin
                    res_d   = cu_result;
                    state_d = ST_WRITE;
                end else if (timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                // Each element consumes an operand pair but produces a single result.
                src_d   = src_q + ADDR_W'(2);
                dst_d   = dst_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                state_d = (cnt_q == ADDR_W'(1)) ? ST_DONE : ST_READ;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        done       = (state_q == ST_DONE);
        cu_start   = (state_q == ST_ISSUE);
        ld_ready   = (state_q != ST_WRITE);
        vrf_r_am   = AM_IDLE;
        vrf_r_addr = '0;
        vrf_w_am   = AM_IDLE;
        vrf_w_addr = '0;
        vrf_w_data = '0;
        if (state_q == ST_READ) begin
            vrf_r_am   = AM_RW;
            vrf_r_addr = src_q;
        end
        // No hazard check against pending reads: the write port is ordered purely by cycle.
        if (state_q == ST_WRITE) begin
            vrf_w_am   = AM_RW;
            vrf_w_addr = dst_q;
            vrf_w_data = res_q;
        end else if (ld_valid) begin
            vrf_w_am   = AM_RW;
            vrf_w_addr = ld_addr;
            vrf_w_data = ld_data;
        end
    end

endmodule

// File: tb/tb_vrf_seq.sv
// Directed bench for vrf_seq: command table plus hand-written reset, load-contention and CU-timeout sequences.
module tb_vrf_seq;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam logic [AW-1:0] LD_A = 5'd17;
    localparam logic [DW-1:0] LD_D = 64'hDEAD_BEEF_0000_1234;
    localparam logic [63:0]   NONE = 64'hBAD0_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src, cmd_dst, cmd_len;
    logic          done, err;
    logic [1:0]    vrf_r_am, vrf_w_am;
    logic [AW-1:0] vrf_r_addr, vrf_w_addr;
    logic [DW-1:0] vrf_w_data;
    logic          cu_start, cu_done;
    logic [DW-1:0] cu_result;
    logic          ld_valid, ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    always #5 clk = ~clk;

    vrf_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .done(done), .err(err),
        .vrf_r_am(vrf_r_am), .vrf_r_addr(vrf_r_addr),
        .vrf_w_am(vrf_w_am), .vrf_w_addr(vrf_w_addr), .vrf_w_data(vrf_w_data),
        .cu_start(cu_start), .cu_done(cu_done), .cu_result(cu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [AW-1:0] src, dst, len;
        logic [DW-1:0] res0, res1;
        int            nrd;
        logic [AW-1:0] rd0, rd1;
        logic [AW-1:0] wa0, wa1;
        int            lat;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Issues one command and, with cu_done one cycle after cu_start, traces the response.
    task automatic run_cmd(input vec_t v, input bit ld_on, input string tag);
        logic [63:0] rd[$];
        logic [63:0] wa[$];
        logic [63:0] wd[$];
        int  done_at = -1;
        bit  pend = 0;
        int  ridx = 0;
        int  ld_bad = 0;
        bit  err_seen = 0;
        bit  fsm_wr;
        ld_valid = ld_on;
        ld_addr  = LD_A;
        ld_data  = LD_D;
        @(negedge clk);
        check({tag, " cmd_ready idle"}, cmd_ready, 1);
        cmd_valid = 1; cmd_src = v.src; cmd_dst = v.dst; cmd_len = v.len;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cmd_valid = 0;
            #1;
            if (vrf_r_am == 2'b01) rd.push_back(64'(vrf_r_addr));
            fsm_wr = ld_on ? !ld_ready : (vrf_w_am == 2'b01);
            if (fsm_wr) begin
                wa.push_back(64'(vrf_w_addr));
                wd.push_back(vrf_w_data);
                if (vrf_w_am != 2'b01) ld_bad++;
            end else if (ld_on && !(vrf_w_am == 2'b01 && vrf_w_addr == LD_A && vrf_w_data == LD_D)) begin
                ld_bad++;
            end
            if (done) begin
                done_at  = k;
                err_seen = err;
            end
            cu_done = 0;
            if (pend) begin
                cu_done   = 1;
                cu_result = (ridx == 0) ? v.res0 : v.res1;
                ridx++;
                pend = 0;
            end
            if (cu_start) pend = 1;
            if (done_at >= 0) break;
        end
        cu_done  = 0;
        ld_valid = 0;
        check({tag, " done latency"}, 64'(done_at), 64'(v.lat));
        check({tag, " err"}, err_seen, 0);
        check({tag, " read count"}, 64'(rd.size()), 64'(v.nrd));
        check({tag, " write count"}, 64'(wa.size()), 64'(v.nrd));
        if (v.nrd > 0) begin
            check({tag, " read0"}, (rd.size() > 0) ? rd[0] : NONE, 64'(v.rd0));
            check({tag, " write0 addr"}, (wa.size() > 0) ? wa[0] : NONE, 64'(v.wa0));
            check({tag, " write0 data"}, (wd.size() > 0) ? wd[0] : NONE, v.res0);
        end
        if (v.nrd > 1) begin
            check({tag, " read1"}, (rd.size() > 1) ? rd[1] : NONE, 64'(v.rd1));
            check({tag, " write1 addr"}, (wa.size() > 1) ? wa[1] : NONE, 64'(v.wa1));
            check({tag, " write1 data"}, (wd.size() > 1) ? wd[1] : NONE, v.res1);
        end
        if (ld_on) check({tag, " load port cycles"}, 64'(ld_bad), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " cu_start"}, cu_start, 0);
        check({tag, " r_am"}, vrf_r_am, 2'b00);
        check({tag, " r_addr"}, vrf_r_addr, 0);
        check({tag, " w_am"}, vrf_w_am, 2'b00);
        check({tag, " w_addr/data"}, {vrf_w_addr, vrf_w_data}, 0);
    endtask

    // Starts a command with no CU response; returns once the DUT is in its first WAIT_CU cycle.
    task automatic start_stalled(input logic [AW-1:0] src, input logic [AW-1:0] dst);
        @(negedge clk);
        cmd_valid = 1; cmd_src = src; cmd_dst = dst; cmd_len = 1;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("stall cu_start", cu_start, 1);
        @(negedge clk);
    endtask

    vec_t vecs[4];
    int   bad;
    int   done_at;
    bit   err_at;
    int   wrote;

    initial begin
        cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0;
        cu_done = 0; cu_result = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;

        vecs[0] = '{src:5'd4,  dst:5'd10, len:5'd2, res0:64'hA1, res1:64'hB2,
                    nrd:2, rd0:5'd4,  rd1:5'd6, wa0:5'd10, wa1:5'd11, lat:9};
        vecs[1] = '{src:5'd31, dst:5'd3,  len:5'd1, res0:64'h5555_0000_AAAA_0001, res1:64'h0,
                    nrd:1, rd0:5'd31, rd1:5'd0, wa0:5'd3,  wa1:5'd0,  lat:5};
        vecs[2] = '{src:5'd30, dst:5'd31, len:5'd2, res0:64'hFFFF_FFFF_FFFF_FFFF, res1:64'h1234,
                    nrd:2, rd0:5'd30, rd1:5'd0, wa0:5'd31, wa1:5'd0,  lat:9};
        vecs[3] = '{src:5'd0,  dst:5'd0,  len:5'd0, res0:64'h0, res1:64'h0,
                    nrd:0, rd0:5'd0,  rd1:5'd0, wa0:5'd0,  wa1:5'd0,  lat:1};

        rst = 1;
        #2 rst = 0;
        #1 check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1;

        for (int i = 0; i < 4; i++) run_cmd(vecs[i], 1'b0, $sformatf("vec%0d", i));

        run_cmd(vecs[0], 1'b1, "load contention");

        // Reset while waiting on the CU drops the element without any write.
        start_stalled(5'd2, 5'd9);
        rst = 0;
        #1 check_idle_outputs("reset in WAIT_CU");
        @(negedge clk);
        rst = 1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (vrf_w_am != 2'b00 || done || !cmd_ready) bad++;
        end
        check("post-reset quiet cycles", 64'(bad), 0);
        run_cmd(vecs[2], 1'b0, "after reset");

        // CU never answers: watchdog build times out, default build stays parked in WAIT_CU.
        start_stalled(5'd7, 5'd20);
        done_at = -1; err_at = 0; wrote = 0;
        for (int k = 1; k <= 30; k++) begin
            if (vrf_w_am != 2'b00) wrote++;
            if (done && done_at < 0) begin
                done_at = k - 1;
                err_at  = err;
            end
            @(negedge clk);
        end
        check("no-response write count", 64'(wrote), 0);
`ifdef VRF_SEQ_TIMEOUT_EN
        check("timeout done offset", 64'(done_at), 64'(8));
        check("timeout err", err_at, 1);
`else
        check("stuck in WAIT_CU no done", 64'(done_at), 64'(-1));
        check("stuck in WAIT_CU cmd_ready", cmd_ready, 0);
        rst = 0;
        @(negedge clk);
        rst = 1;
`endif
        run_cmd(vecs[1], 1'b0, "after stall");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
